// File: rtl/digit_pkg.sv
// Shared constants and types for the decimal digit field sequencer.
package digit_pkg;

    localparam logic [3:0] BLANK_DIGIT = 4'hF;
    localparam int         DIGIT_W     = 30;
    localparam int         DIGIT_H     = 50;

    typedef enum logic {IDLE, SHIFT} dctl_state_t;
    typedef logic [3:0] bcd_t;

    // Double-dabble correction applied to each nibble before the shift.
    function automatic bcd_t add3(input bcd_t n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Multi-cycle binary to BCD converter: one shift-add-3 step per clock, MSB first.
module bin2bcd_seq
    import digit_pkg::*;
#(
    parameter int VAL_W      = 10,
    parameter int NUM_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [VAL_W-1:0]        value,
    output logic                    done,
    output logic [NUM_DIGITS*4-1:0] bcd,
    output dctl_state_t             state
);

    localparam int BW = NUM_DIGITS * 4;
    localparam int CW = $clog2(VAL_W + 1);

    logic [VAL_W-1:0] shreg;
    logic [BW-1:0]    acc;
    logic [BW-1:0]    acc_adj;
    logic [BW-1:0]    acc_next;
    logic [CW-1:0]    cnt;

    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            acc_adj[4*i +: 4] = add3(acc[4*i +: 4]);
        end
        acc_next = {acc_adj[BW-2:0], shreg[VAL_W-1]};
    end

    // done marks the final shift; bcd then carries the finished result so the
    // caller can capture it on the same edge the FSM drops back to IDLE.
    assign done = (state == SHIFT) && (cnt == CW'(VAL_W - 1));
    assign bcd  = acc_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            shreg <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg <= value;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg <= shreg << 1;
                    acc   <= acc_next;
                    cnt   <= cnt + CW'(1);
                    if (done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/digit_display_ctrl.sv
// Tear-free N-digit decimal field: converts values to BCD, commits at frame start,
// and steers the shared glyph renderer to the slot under the raster.
module digit_display_ctrl
    import digit_pkg::*;
#(
    parameter int         NUM_DIGITS = 3,
    parameter int         VAL_W      = 10,
    parameter logic [9:0] X0         = 10'd560,
    parameter logic [9:0] Y0         = 10'd16,
    parameter bit         LZ_BLANK   = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [VAL_W-1:0] i_value,
    input  logic             i_value_valid,
    output logic             o_value_ready,
    input  logic             i_frame_start,
    input  logic [9:0]       i_x_cnt,
    input  logic [9:0]       i_y_cnt,
    output logic [3:0]       o_number,
    output logic [9:0]       o_x_pin,
    output logic [9:0]       o_y_pin,
    output logic [9:0]       o_x_width,
    output logic [9:0]       o_y_width,
    output logic             o_active,
    output logic             o_busy,
    output dctl_state_t      o_dbg_state
);

    localparam int          BW      = NUM_DIGITS * 4;
    localparam logic [31:0] MAX_VAL = 32'(10 ** NUM_DIGITS - 1);

    if (32'(X0) + NUM_DIGITS * DIGIT_W > 1023) begin : g_field_overflow
        $error("digit field extends past column 1023");
    end

    dctl_state_t      state;
    logic             accept;
    logic             conv_done;
    logic [BW-1:0]    conv_bcd;
    logic [VAL_W-1:0] sat_value;
    logic [BW-1:0]    pending;
    logic             pending_valid;
    logic [BW-1:0]    display;

    // Handshake: o_value_ready is high whenever the converter is idle and reset
    // is released; ready never looks at valid. A value transfers on any rising
    // edge where i_value_valid && o_value_ready; valid may be held high.
    assign o_value_ready = i_rst_n && (state == IDLE);
    assign accept        = i_value_valid && o_value_ready;
    assign o_busy        = (state == SHIFT);
    assign o_dbg_state   = state;

    assign sat_value = (32'(i_value) > MAX_VAL) ? VAL_W'(MAX_VAL) : i_value;

    bin2bcd_seq #(
        .VAL_W      (VAL_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_conv (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .start (accept),
        .value (sat_value),
        .done  (conv_done),
        .bcd   (conv_bcd),
        .state (state)
    );

    // A finish coinciding with frame start keeps the new result pending; the
    // commit on that edge sees only the previously pending value.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pending       <= '0;
            pending_valid <= 1'b0;
            display       <= '0;
        end else begin
            if (i_frame_start && pending_valid) begin
                display <= pending;
            end
            if (conv_done) begin
                pending       <= conv_bcd;
                pending_valid <= 1'b1;
            end else if (i_frame_start) begin
                pending_valid <= 1'b0;
            end
        end
    end

    logic [NUM_DIGITS-1:0] blank;
    logic                  zero_run;

    always_comb begin
        zero_run = 1'b1;
        blank    = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            zero_run = zero_run && (display[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
            blank[k] = LZ_BLANK && zero_run && (k != NUM_DIGITS - 1);
        end
    end

    logic in_rows;

    always_comb begin
        in_rows  = (i_y_cnt >= Y0) && (i_y_cnt <= 10'(32'(Y0) + DIGIT_H - 1));
        o_active = 1'b0;
        o_number = BLANK_DIGIT;
        o_x_pin  = X0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (in_rows
                && (i_x_cnt >= 10'(32'(X0) + k * DIGIT_W))
                && (i_x_cnt <= 10'(32'(X0) + k * DIGIT_W + DIGIT_W - 1))) begin
                o_active = 1'b1;
                o_x_pin  = 10'(32'(X0) + k * DIGIT_W);
                o_number = blank[k] ? BLANK_DIGIT : display[4*(NUM_DIGITS-1-k) +: 4];
            end
        end
    end

    assign o_y_pin   = Y0;
    assign o_x_width = 10'(DIGIT_W - 1);
    assign o_y_width = 10'(DIGIT_H - 1);

endmodule

// File: tb/tb_digit_display_ctrl.sv
// Directed bench for digit_display_ctrl: handshake timing, frame commit, blanking, raster decode.
module tb_digit_display_ctrl;
    import digit_pkg::*;

    localparam logic [9:0] X0 = 10'd560;
    localparam logic [9:0] Y0 = 10'd16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  i_value = '0;
    logic        i_value_valid = 1'b0;
    logic        o_value_ready;
    logic        i_frame_start = 1'b0;
    logic [9:0]  i_x_cnt = '0;
    logic [9:0]  i_y_cnt = '0;
    logic [3:0]  o_number;
    logic [9:0]  o_x_pin;
    logic [9:0]  o_y_pin;
    logic [9:0]  o_x_width;
    logic [9:0]  o_y_width;
    logic        o_active;
    logic        o_busy;
    dctl_state_t o_dbg_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    digit_display_ctrl #(
        .NUM_DIGITS (3),
        .VAL_W      (10),
        .X0         (X0),
        .Y0         (Y0),
        .LZ_BLANK   (1'b1)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_value       (i_value),
        .i_value_valid (i_value_valid),
        .o_value_ready (o_value_ready),
        .i_frame_start (i_frame_start),
        .i_x_cnt       (i_x_cnt),
        .i_y_cnt       (i_y_cnt),
        .o_number      (o_number),
        .o_x_pin       (o_x_pin),
        .o_y_pin       (o_y_pin),
        .o_x_width     (o_x_width),
        .o_y_width     (o_y_width),
        .o_active      (o_active),
        .o_busy        (o_busy),
        .o_dbg_state   (o_dbg_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_pulse();
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
    endtask

    task automatic get_digit(input int k, output logic [3:0] n);
        i_y_cnt = Y0 + 10'd20;
        i_x_cnt = 10'(X0 + k * 30 + 5);
        #1;
        n = o_number;
    endtask

    // Returns just after the accepting edge.
    task automatic send_value(input logic [9:0] v);
        int n;
        n = 0;
        i_value       = v;
        i_value_valid = 1'b1;
        while (!o_value_ready && n < 50) begin
            tick();
            n++;
        end
        if (!o_value_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout ready=%b required=1", o_value_ready);
        end
        tick();
        i_value_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (o_busy && n < 50) begin
            tick();
            n++;
        end
        if (o_busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout busy=%b required=0", o_busy);
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_d [3];
        logic [3:0] n;
        exp_d = '{4'hF, 4'hF, 4'h0};
        rst_n = 1'b0;
        tick();
        checks++;
        if (o_value_ready !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_held ready=%b busy=%b required 0/0", o_value_ready, o_busy);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (o_value_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got=%b required=1", o_value_ready);
        end
        for (int k = 0; k < 3; k++) begin
            get_digit(k, n);
            checks++;
            if (n !== exp_d[k]) begin
                errors++;
                $display("FAIL reset_slot%0d got=%h required=%h", k, n, exp_d[k]);
            end
        end
        frame_pulse();
        for (int k = 0; k < 3; k++) begin
            get_digit(k, n);
            checks++;
            if (n !== exp_d[k]) begin
                errors++;
                $display("FAIL empty_frame_slot%0d got=%h required=%h", k, n, exp_d[k]);
            end
        end
    endtask

    task automatic test_convert_427();
        logic [3:0] exp_old [3];
        logic [3:0] exp_new [3];
        logic [3:0] n;
        exp_old = '{4'hF, 4'hF, 4'h0};
        exp_new = '{4'h4, 4'h2, 4'h7};
        send_value(10'd427);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (o_value_ready !== 1'b0 || o_busy !== 1'b1) begin
                errors++;
                $display("FAIL shift_cycle%0d ready=%b busy=%b required 0/1", i + 1, o_value_ready, o_busy);
            end
            tick();
        end
        checks++;
        if (o_value_ready !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL convert_end ready=%b busy=%b required 1/0", o_value_ready, o_busy);
        end
        for (int k = 0; k < 3; k++) begin
            get_digit(k, n);
            checks++;
            if (n !== exp_old[k]) begin
                errors++;
                $display("FAIL precommit_slot%0d got=%h required=%h", k, n, exp_old[k]);
            end
        end
        frame_pulse();
        for (int k = 0; k < 3; k++) begin
            get_digit(k, n);
            checks++;
            if (n !== exp_new[k]) begin
                errors++;
                $display("FAIL commit427_slot%0d got=%h required=%h", k, n, exp_new[k]);
            end
        end
    endtask

    task automatic test_blank_saturate();
        logic [3:0] exp_a [3];
        logic [3:0] exp_b [3];
        logic [3:0] n;
        exp_a = '{4'hF, 4'hF, 4'h7};
        exp_b = '{4'h9, 4'h9, 4'h9};
        send_value(10'd7);
        wait_idle();
        frame_pulse();
        for (int k = 0; k < 3; k++) begin
            get_digit(k, n);
            checks++;
            if (n !== exp_a[k]) begin
                errors++;
                $display("FAIL value7_slot%0d got=%h required=%h", k, n, exp_a[k]);
            end
        end
        send_value(10'd1000);
        wait_idle();
        frame_pulse();
        for (int k = 0; k < 3; k++) begin
            get_digit(k, n);
            checks++;
            if (n !== exp_b[k]) begin
                errors++;
                $display("FAIL saturate_slot%0d got=%h required=%h", k, n, exp_b[k]);
            end
        end
        i_x_cnt = 10'd0;
        i_y_cnt = 10'd0;
        #1;
        checks++;
        if (o_active !== 1'b0 || o_number !== 4'hF || o_x_pin !== X0) begin
            errors++;
            $display("FAIL outside_field active=%b number=%h x_pin=%0d required 0/f/%0d",
                     o_active, o_number, o_x_pin, X0);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_a [3];
        logic [3:0] exp_b [3];
        logic [3:0] n;
        exp_a = '{4'h3, 4'h0, 4'h5};
        exp_b = '{4'hF, 4'h1, 4'h2};
        send_value(10'd12);
        wait_idle();
        send_value(10'd305);
        wait_idle();
        frame_pulse();
        for (int k = 0; k < 3; k++) begin
            get_digit(k, n);
            checks++;
            if (n !== exp_a[k]) begin
                errors++;
                $display("FAIL last_wins_slot%0d got=%h required=%h", k, n, exp_a[k]);
            end
        end
        // Frame start lands on the edge where the conversion of 12 finishes.
        send_value(10'd12);
        repeat (9) tick();
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
        checks++;
        if (o_value_ready !== 1'b1) begin
            errors++;
            $display("FAIL finish_edge_ready got=%b required=1", o_value_ready);
        end
        for (int k = 0; k < 3; k++) begin
            get_digit(k, n);
            checks++;
            if (n !== exp_a[k]) begin
                errors++;
                $display("FAIL same_edge_hold_slot%0d got=%h required=%h", k, n, exp_a[k]);
            end
        end
        frame_pulse();
        for (int k = 0; k < 3; k++) begin
            get_digit(k, n);
            checks++;
            if (n !== exp_b[k]) begin
                errors++;
                $display("FAIL next_frame_slot%0d got=%h required=%h", k, n, exp_b[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp_d [3];
        logic [3:0] n;
        exp_d = '{4'hF, 4'hF, 4'h0};
        send_value(10'd123);
        repeat (4) tick();
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_shift_busy got=%b required=1", o_busy);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (o_busy !== 1'b0 || o_value_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset busy=%b ready=%b required 0/0", o_busy, o_value_ready);
        end
        rst_n = 1'b1;
        tick();
        frame_pulse();
        for (int k = 0; k < 3; k++) begin
            get_digit(k, n);
            checks++;
            if (n !== exp_d[k]) begin
                errors++;
                $display("FAIL abort_no_commit_slot%0d got=%h required=%h", k, n, exp_d[k]);
            end
        end
    endtask

    task automatic test_raster();
        logic       exp_act;
        logic [9:0] exp_pin;
        logic [3:0] exp_num;
        int         slot;
        checks++;
        if (o_y_pin !== 10'd16 || o_x_width !== 10'd29 || o_y_width !== 10'd49) begin
            errors++;
            $display("FAIL geometry y_pin=%0d x_w=%0d y_w=%0d required 16/29/49",
                     o_y_pin, o_x_width, o_y_width);
        end
        // Display holds 0 here, so only the LSD slot draws a digit.
        for (int x = 559; x <= 650; x++) begin
            i_y_cnt = Y0 + 10'd20;
            i_x_cnt = 10'(x);
            #1;
            exp_act = (x >= 560) && (x <= 649);
            slot    = (x - 560) / 30;
            exp_pin = exp_act ? 10'(560 + slot * 30) : X0;
            exp_num = (exp_act && slot == 2) ? 4'h0 : 4'hF;
            checks++;
            if (o_active !== exp_act || o_x_pin !== exp_pin || o_number !== exp_num) begin
                errors++;
                $display("FAIL sweep_x%0d active=%b x_pin=%0d number=%h required %b/%0d/%h",
                         x, o_active, o_x_pin, o_number, exp_act, exp_pin, exp_num);
            end
        end
        for (int i = 0; i < 4; i++) begin
            int y;
            y = (i == 0) ? 15 : (i == 1) ? 16 : (i == 2) ? 65 : 66;
            exp_act = (i == 1) || (i == 2);
            i_x_cnt = 10'd640;
            i_y_cnt = 10'(y);
            #1;
            checks++;
            if (o_active !== exp_act) begin
                errors++;
                $display("FAIL row_edge_y%0d active=%b required=%b", y, o_active, exp_act);
            end
        end
    endtask

    initial begin
        test_reset();
        test_convert_427();
        test_blank_saturate();
        test_back_to_back();
        test_reset_mid();
        test_raster();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time_limit_reached required=finish");
        $fatal(1, "watchdog");
    end

endmodule
